// File: rtl/tt_um_stone_paper_scissors.sv
// Two-player stone/paper/scissors referee: scores a round on each start rising edge.
// Latency: 1 clock from the firing edge to result, counters, done and valid.
// Backpressure: none; the minimum round period is 2 clocks and a held start fires once.
//
// Ports:
//   clk      system clock, all state updates on its rising edge
//   rst_n    synchronous reset, active-HIGH despite the tile-standard name
//   ena      tile enable; start edges are ignored while low
//   ui_in    [1:0] P1 move, [3:2] P2 move, [4] start, [7:5] unused
//   uo_out   [1:0] result, [2] done pulse, [3] valid (sticky), [7:4] round count
//   uio_in   unused
//   uio_out  [3:0] P1 win count, [7:4] P2 win count (both saturating)
//   uio_oe   constant 8'hFF
//   vccd1/vssd1  power pins, present only when POWER_PINS_EN is defined
//
// Moves: 00 stone, 01 paper, 10 scissors, 11 invalid.
// Results: 00 tie, 01 P1 wins, 10 P2 wins, 11 invalid.

module tt_um_stone_paper_scissors (
`ifdef POWER_PINS_EN
  inout  wire        vccd1,
  inout  wire        vssd1,
`endif
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam logic [1:0] RES_TIE = 2'b00;
  localparam logic [1:0] RES_P1  = 2'b01;
  localparam logic [1:0] RES_P2  = 2'b10;
  localparam logic [1:0] RES_INV = 2'b11;

  logic [1:0] p1_move;
  logic [1:0] p2_move;
  logic       start;

  assign p1_move = ui_in[1:0];
  assign p2_move = ui_in[3:2];
  assign start   = ui_in[4];

  logic       start_q;
  // Set when start was already high at the last reset edge. start_q resets to
  // 0, so without this a start held through reset would look like a fresh
  // rising edge on the first edge after release.
  logic       start_held_rst;
  logic [1:0] result;
  logic       done;
  logic       valid;
  logic [3:0] round_cnt;
  logic [3:0] p1_cnt;
  logic [3:0] p2_cnt;

  logic       fire;
  logic [1:0] next_result;

  assign fire = ena & start & ~start_q & ~start_held_rst;

  always_comb begin
    next_result = RES_P2;
    if (p1_move == 2'b11 || p2_move == 2'b11) begin
      next_result = RES_INV;
    end else if (p1_move == p2_move) begin
      next_result = RES_TIE;
    end else if ((p1_move == 2'b00 && p2_move == 2'b10) ||
                 (p1_move == 2'b01 && p2_move == 2'b00) ||
                 (p1_move == 2'b10 && p2_move == 2'b01)) begin
      next_result = RES_P1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      start_q        <= 1'b0;
      start_held_rst <= start;
      result         <= RES_TIE;
      done           <= 1'b0;
      valid          <= 1'b0;
      round_cnt      <= 4'd0;
      p1_cnt         <= 4'd0;
      p2_cnt         <= 4'd0;
    end else begin
      // Edge detector samples start every cycle, even with ena low, so that
      // raising ena while start is already high does not fire a round.
      start_q        <= start;
      start_held_rst <= 1'b0;
      done           <= fire;
      if (fire) begin
        result    <= next_result;
        valid     <= 1'b1;
        round_cnt <= round_cnt + 4'd1;
        if (next_result == RES_P1 && p1_cnt != 4'hF) begin
          p1_cnt <= p1_cnt + 4'd1;
        end
        if (next_result == RES_P2 && p2_cnt != 4'hF) begin
          p2_cnt <= p2_cnt + 4'd1;
        end
      end
    end
  end

  assign uo_out  = {round_cnt, valid, done, result};
  assign uio_out = {p2_cnt, p1_cnt};
  assign uio_oe  = 8'hFF;

  logic unused_ok;
`ifdef POWER_PINS_EN
  assign unused_ok = &{1'b0, ui_in[7:5], uio_in, vccd1, vssd1};
`else
  assign unused_ok = &{1'b0, ui_in[7:5], uio_in};
`endif

endmodule

// File: tb/tb_tt_um_stone_paper_scissors.sv
// Self-checking bench for the stone/paper/scissors referee.
// Inputs change and outputs are sampled on the falling clock edge.
// Expected rounds are queued when a start is driven and popped on done.

module tb_tt_um_stone_paper_scissors;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  wire  [7:0] uo_out;
  wire  [7:0] uio_out;
  wire  [7:0] uio_oe;

`ifdef POWER_PINS_EN
  wire vccd1 = 1'b1;
  wire vssd1 = 1'b0;
`endif

  tt_um_stone_paper_scissors dut (
`ifdef POWER_PINS_EN
    .vccd1   (vccd1),
    .vssd1   (vssd1),
`endif
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [1:0] res;
    logic [3:0] rnd;
    logic [3:0] c1;
    logic [3:0] c2;
  } exp_t;

  exp_t sb[$];

  // Reference model state
  logic [1:0] m_res;
  logic [3:0] m_round;
  logic [3:0] m_p1;
  logic [3:0] m_p2;
  logic       m_valid;

  // Independent formulation: (a - b) mod 3 == 1 means a beats b.
  function automatic logic [1:0] ref_result(input logic [1:0] a, input logic [1:0] b);
    int d;
    if (a == 2'b11 || b == 2'b11) return 2'b11;
    d = (int'(a) + 3 - int'(b)) % 3;
    if (d == 0) return 2'b00;
    if (d == 1) return 2'b01;
    return 2'b10;
  endfunction

  task automatic model_reset();
    m_res = 2'b00; m_round = 4'd0; m_p1 = 4'd0; m_p2 = 4'd0; m_valid = 1'b0;
    sb.delete();
  endtask

  task automatic push_round(input logic [1:0] p1, input logic [1:0] p2);
    exp_t e;
    logic [1:0] r;
    r = ref_result(p1, p2);
    m_round = m_round + 4'd1;
    if (r == 2'b01 && m_p1 != 4'hF) m_p1 = m_p1 + 4'd1;
    if (r == 2'b10 && m_p2 != 4'hF) m_p2 = m_p2 + 4'd1;
    m_res = r;
    m_valid = 1'b1;
    e.res = r; e.rnd = m_round; e.c1 = m_p1; e.c2 = m_p2;
    sb.push_back(e);
  endtask

  // Wait (bounded) for done, then pop the oldest expected round and compare.
  task automatic collect(input string name);
    exp_t e;
    bit   seen;
    seen = 0;
    for (int i = 0; i < 4 && !seen; i++) begin
      if (uo_out[2] === 1'b1) seen = 1;
      else @(negedge clk);
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL %s done_timeout: uo_out=%h, required done=1 within 4 cycles", name, uo_out);
      if (sb.size() != 0) void'(sb.pop_front());
    end else begin
      e = sb.pop_front();
      n_checks++;
      if ({uo_out[7:4], uo_out[3], uo_out[1:0]} !== {e.rnd, 1'b1, e.res}) begin
        n_fail++;
        $display("FAIL %s uo_out: got rnd=%h valid=%b res=%b, required rnd=%h valid=1 res=%b",
                 name, uo_out[7:4], uo_out[3], uo_out[1:0], e.rnd, e.res);
      end
      n_checks++;
      if (uio_out !== {e.c2, e.c1}) begin
        n_fail++;
        $display("FAIL %s uio_out: got %h, required %h", name, uio_out, {e.c2, e.c1});
      end
    end
  endtask

  task automatic play(input logic [1:0] p1, input logic [1:0] p2, input string name);
    ui_in = {3'b000, 1'b1, p2, p1};
    push_round(p1, p2);
    @(negedge clk);
    ui_in[4] = 1'b0;
    collect(name);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    ena = 1'b1; ui_in = 8'h00; uio_in = 8'h00;
    do_reset();
    n_checks++;
    if (uo_out !== 8'h00) begin
      n_fail++; $display("FAIL reset_uo_out: got %h, required 00", uo_out);
    end
    n_checks++;
    if (uio_out !== 8'h00) begin
      n_fail++; $display("FAIL reset_uio_out: got %h, required 00", uio_out);
    end
    n_checks++;
    if (uio_oe !== 8'hFF) begin
      n_fail++; $display("FAIL reset_uio_oe: got %h, required FF", uio_oe);
    end
  endtask

  task automatic test_rules();
    play(2'b00, 2'b10, "rule_stone_scissors");
    play(2'b01, 2'b00, "rule_paper_stone");
    play(2'b10, 2'b01, "rule_scissors_paper");
    play(2'b00, 2'b01, "rule_stone_paper");
    play(2'b01, 2'b01, "rule_tie");
    play(2'b11, 2'b00, "rule_invalid");
    @(negedge clk);
    n_checks++;
    if (uo_out[1:0] !== 2'b11) begin
      n_fail++; $display("FAIL rules_result_hold: got %b, required 11", uo_out[1:0]);
    end
    n_checks++;
    if (uo_out[7:3] !== {4'd6, 1'b1}) begin
      n_fail++; $display("FAIL rules_round_valid: got rnd=%h valid=%b, required rnd=6 valid=1",
                         uo_out[7:4], uo_out[3]);
    end
    n_checks++;
    if (uio_out !== 8'h13) begin
      n_fail++; $display("FAIL rules_counts: got %h, required 13", uio_out);
    end
  endtask

  task automatic test_held_start();
    int extra;
    logic [3:0] p1_before;
    p1_before = uio_out[3:0];
    extra = 0;
    ui_in = {3'b000, 1'b1, 2'b10, 2'b00};
    push_round(2'b00, 2'b10);
    @(negedge clk);
    collect("held_first");
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (uo_out[2] !== 1'b0) extra++;
    end
    ui_in[4] = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (uo_out[2] !== 1'b0) extra++;
    end
    n_checks++;
    if (extra != 0) begin
      n_fail++; $display("FAIL held_single_done: extra done cycles %0d, required 0", extra);
    end
    n_checks++;
    if (uio_out[3:0] !== p1_before + 4'd1) begin
      n_fail++; $display("FAIL held_p1_count: got %h, required %h", uio_out[3:0], p1_before + 4'd1);
    end
    n_checks++;
    if (uo_out[7:4] !== m_round) begin
      n_fail++; $display("FAIL held_round: got %h, required %h", uo_out[7:4], m_round);
    end
  endtask

  task automatic test_move_change();
    ui_in = {3'b000, 1'b0, 2'b00, 2'b01};
    @(negedge clk);
    ui_in = {3'b000, 1'b0, 2'b11, 2'b11};
    @(negedge clk);
    ui_in = {3'b000, 1'b0, 2'b01, 2'b10};
    repeat (2) @(negedge clk);
    n_checks++;
    if (uo_out !== {m_round, m_valid, 1'b0, m_res}) begin
      n_fail++; $display("FAIL move_change_uo_out: got %h, required %h", uo_out, {m_round, m_valid, 1'b0, m_res});
    end
    n_checks++;
    if (uio_out !== {m_p2, m_p1}) begin
      n_fail++; $display("FAIL move_change_uio_out: got %h, required %h", uio_out, {m_p2, m_p1});
    end
  endtask

  task automatic test_enable();
    int dones;
    dones = 0;
    ena = 1'b0;
    ui_in = {3'b000, 1'b1, 2'b00, 2'b01};
    @(negedge clk);
    if (uo_out[2] !== 1'b0) dones++;
    ui_in[4] = 1'b0;
    @(negedge clk);
    if (uo_out[2] !== 1'b0) dones++;
    ui_in[4] = 1'b1;
    @(negedge clk);
    if (uo_out[2] !== 1'b0) dones++;
    ena = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (uo_out[2] !== 1'b0) dones++;
    end
    ui_in[4] = 1'b0;
    @(negedge clk);
    n_checks++;
    if (dones != 0) begin
      n_fail++; $display("FAIL ena_no_round: done seen %0d times, required 0", dones);
    end
    n_checks++;
    if ({uo_out, uio_out} !== {m_round, m_valid, 1'b0, m_res, m_p2, m_p1}) begin
      n_fail++; $display("FAIL ena_state_hold: got %h_%h, required %h_%h",
                         uo_out, uio_out, {m_round, m_valid, 1'b0, m_res}, {m_p2, m_p1});
    end
  endtask

  task automatic test_saturate_wrap();
    do_reset();
    for (int i = 0; i < 16; i++) play(2'b01, 2'b00, "sat_round");
    n_checks++;
    if (uio_out !== 8'h0F) begin
      n_fail++; $display("FAIL sat_p1_count: got %h, required 0F", uio_out);
    end
    n_checks++;
    if (uo_out !== 8'h09) begin
      n_fail++; $display("FAIL wrap_uo_out: got %h, required 09", uo_out);
    end
  endtask

  task automatic test_reset_priority();
    int dones;
    dones = 0;
    rst_n = 1'b1;
    ui_in = {3'b000, 1'b1, 2'b01, 2'b10};
    @(negedge clk);
    model_reset();
    n_checks++;
    if ({uo_out, uio_out} !== 16'h0000) begin
      n_fail++; $display("FAIL rst_prio_outputs: got %h_%h, required 00_00", uo_out, uio_out);
    end
    // Release reset with start still high: no round until it drops and rises.
    rst_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (uo_out[2] !== 1'b0) dones++;
    end
    n_checks++;
    if (dones != 0 || uo_out !== 8'h00) begin
      n_fail++; $display("FAIL rst_held_start: done=%0d uo_out=%h, required done=0 uo_out=00", dones, uo_out);
    end
    ui_in[4] = 1'b0;
    @(negedge clk);
    play(2'b10, 2'b01, "post_reset_round");
  endtask

  initial begin
    rst_n = 1'b1; ena = 1'b1; ui_in = 8'h00; uio_in = 8'h00;
    model_reset();
    @(negedge clk);
    test_reset();
    test_rules();
    test_held_start();
    test_move_change();
    test_enable();
    test_saturate_wrap();
    test_reset_priority();
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++; $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
